aes_round_sequencer: RTL and testbench

- Iterative AES-128 encryption engine controller. Owns the 128-bit state register and a round counter.
- Each clock, it steps the state through one round: sub_bytes -> shift_rows -> mix_columns -> AddRoundKey. The final round bypasses mix_columns.
- It fetches round keys from an external key store by index.
- Sits between the block-level valid/ready input interface and the ciphertext output interface.

---
 rtl/aes_round_sequencer_if.sv | 25 ++
 rtl/aes_round_sequencer.sv | 146 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// Block-level handshake bundle for the AES round sequencer: plaintext in,
// ciphertext out, and the round-key fetch path to the external key store.
interface aes_round_sequencer_if #(
    parameter int KIDX_W = 4
);
    logic              i_valid;
    logic              o_ready;
    logic [127:0]      i_data;
    logic [KIDX_W-1:0] o_key_idx;
    logic [127:0]      i_round_key;
    logic              o_valid;
    logic              i_ready;
    logic [127:0]      o_data;
    logic              o_busy;

    modport slave (
        input  i_valid, i_data, i_round_key, i_ready,
        output o_ready, o_key_idx, o_valid, o_data, o_busy
    );

    modport master (
        output i_valid, i_data, i_round_key, i_ready,
        input  o_ready, o_key_idx, o_valid, o_data, o_busy
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption engine: one full round per clock on a 128-bit state register.
// Latency: ciphertext valid NUM_ROUNDS cycles after the acceptance edge; II = NUM_ROUNDS+2.
// Backpressure: result holds in DONE with o_data frozen until i_ready; no input buffering.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int KIDX_W     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    aes_round_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [KIDX_W-1:0] LAST_RND  = KIDX_W'(NUM_ROUNDS - 1);
    localparam logic [KIDX_W-1:0] FINAL_IDX = KIDX_W'(NUM_ROUNDS);

    // Forward S-box, row-major: entry x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[127 - 8 * k -: 8] = sbox(s[127 - 8 * k -: 8]);
        return r;
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    logic [1:0]        fsm;
    logic [KIDX_W-1:0] rnd;
    logic [127:0]      state_reg;
    logic [127:0]      sr_out;
    logic [127:0]      mc_out;
    logic [KIDX_W-1:0] key_idx;

    assign sr_out = shift_rows(sub_bytes(state_reg));
    assign mc_out = mix_columns(sr_out);

    // Key index depends only on registered state, so the key store sees no
    // combinational path from any block input.
    always_comb begin
        key_idx = '0;
        case (fsm)
            S_ROUND:         key_idx = rnd;
            S_FINAL, S_DONE: key_idx = FINAL_IDX;
            default:         key_idx = '0;
        endcase
    end

    assign bus.o_key_idx = key_idx;
    assign bus.o_ready   = (fsm == S_IDLE);
    assign bus.o_valid   = (fsm == S_DONE);
    assign bus.o_busy    = (fsm != S_IDLE);
    assign bus.o_data    = state_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm       <= S_IDLE;
            rnd       <= '0;
            state_reg <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        state_reg <= bus.i_data ^ bus.i_round_key;
                        rnd       <= KIDX_W'(1);
                        fsm       <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_reg <= mc_out ^ bus.i_round_key;
                    rnd       <= rnd + KIDX_W'(1);
                    if (rnd == LAST_RND)
                        fsm <= S_FINAL;
                end
                S_FINAL: begin
                    state_reg <= sr_out ^ bus.i_round_key;
                    fsm       <= S_DONE;
                end
                S_DONE: begin
                    if (bus.i_ready) begin
                        rnd <= '0;
                        fsm <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer using FIPS-197 vectors; round keys come
// from a key-expansion model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_round_sequencer;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic i_clk;
    logic i_rst_n;

    aes_round_sequencer_if #(.KIDX_W(4)) bus ();

    aes_round_sequencer #(.NUM_ROUNDS(10), .KIDX_W(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests  = 0;
    int failed = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk [2][11];
    logic         key_sel;

    always_comb begin
        bus.i_round_key = '0;
        if (bus.o_key_idx <= 4'd10)
            bus.i_round_key = rk[key_sel][bus.o_key_idx];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input int sel, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk[sel][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    int           acc_t [2];
    int           n_acc;
    int           n_out;
    int           lat;
    logic [127:0] outs [2];

    initial begin
        i_rst_n     = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        key_sel     = 1'b0;
        build_sbox();
        expand_key(0, KEY_B);
        expand_key(1, KEY_C);

        // Reset state
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_ready", bus.o_ready, 1);
        check("rst_valid", bus.o_valid, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_key_idx", bus.o_key_idx, 0);
        check("rst_data", bus.o_data, 0);

        // App. B with key-index trace, then 20 cycles of backpressure
        bus.i_valid = 1'b1;
        bus.i_data  = PT_B;
        @(posedge i_clk);
        #1 bus.i_valid = 1'b0;
        for (int m = 0; m <= 10; m++) begin
            @(negedge i_clk);
            check("key_idx_trace", bus.o_key_idx, (m < 9) ? m + 1 : 10);
            check("valid_latency", bus.o_valid, (m == 10) ? 1 : 0);
        end
        check("ct_app_b", bus.o_data, CT_B);
        bus.i_valid = 1'b1;
        bus.i_data  = PT_C;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            check("bp_valid", bus.o_valid, 1);
            check("bp_data", bus.o_data, CT_B);
            check("bp_ready", bus.o_ready, 0);
            check("bp_key_idx", bus.o_key_idx, 10);
        end
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        check("release_ready", bus.o_ready, 1);
        check("release_valid", bus.o_valid, 0);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;

        // Back-to-back: B then C.1 with valid/ready held high
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_data  = PT_B;
        bus.i_ready = 1'b1;
        key_sel     = 1'b0;
        n_acc = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 40 && n_out < 2; cyc++) begin
            if (bus.o_ready && bus.i_valid && n_acc < 2) begin
                acc_t[n_acc] = cyc;
                n_acc++;
            end
            if (bus.o_valid && bus.i_ready) begin
                outs[n_out] = bus.o_data;
                n_out++;
            end
            @(posedge i_clk);
            #1;
            if (n_acc == 1) bus.i_data = PT_C;
            if (n_acc == 2) bus.i_valid = 1'b0;
            if (n_out == 1) key_sel = 1'b1;
            @(negedge i_clk);
        end
        check("b2b_outputs", n_out, 2);
        check("b2b_ct_b", outs[0], CT_B);
        check("b2b_ct_c", outs[1], CT_C);
        check("b2b_interval", acc_t[1] - acc_t[0], 12);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        key_sel     = 1'b0;

        // Mid-operation asynchronous reset, then a fresh block
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_data  = PT_B;
        @(posedge i_clk);
        #1 bus.i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("abort_busy", bus.o_busy, 0);
        check("abort_valid", bus.o_valid, 0);
        check("abort_data", bus.o_data, 0);
        check("abort_key_idx", bus.o_key_idx, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("post_rst_ready", bus.o_ready, 1);
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_data  = PT_B;
        bus.i_ready = 1'b1;
        @(posedge i_clk);
        #1 bus.i_valid = 1'b0;
        lat = 0;
        while (!bus.o_valid && lat < 20) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        check("post_rst_latency", lat, 10);
        check("post_rst_ct_b", bus.o_data, CT_B);
        @(posedge i_clk);
        #1;
        check("post_rst_idle", bus.o_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
